pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage core. It generates stall (hold) and flush (bubble) controls for the pc, if_id, id_ex, ex_mem and mem_wb stage registers. It covers load-use hazards, taken-branch redirects, multi-cycle EX operations (mul/div handshake) and data-memory wait states. It sits beside the stage registers; the id_ex register consumes stall_id_ex/flush_id_ex directly.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } mc_state_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detection between the instruction in ID and a load in EX.
// Purely combinational so the forwarding unit can share it.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RS_W = 6
) (
    input  logic [RS_W-1:0] id_rs1,
    input  logic [RS_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RS_W-1:0] ex_wd,
    input  logic            ex_wreg,
    input  logic            ex_rmem,
    output logic            load_use
);

    logic wd_live;
    logic hit_rs1;
    logic hit_rs2;

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign wd_live  = ex_rmem & ex_wreg & (ex_wd != RS_W'(REG_ZERO));
    assign hit_rs1  = id_use_rs1 & (id_rs1 == ex_wd);
    assign hit_rs2  = id_use_rs2 & (id_rs2 == ex_wd);
    assign load_use = wd_live & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generation for the 5-stage pipeline: load-use, branch redirect,
// multi-cycle EX ops and data-memory wait states.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal flow; branch, mc_start and load-use resolved each cycle
//   MC_WAIT | multi-cycle op in EX; front end held until done or timeout
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RS_W       = 6,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RS_W-1:0]  id_rs1,
    input  logic [RS_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RS_W-1:0]  ex_wd,
    input  logic             ex_wreg,
    input  logic             ex_rmem,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             mem_wait,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             mc_busy,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int          TO_W    = $clog2(MC_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

    mc_state_t       state, state_nxt;
    logic            done_seen, done_seen_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            mc_err_set;
    logic            load_use;
    pipe_ctl_t       ctl;

    pipe_hazard_ctrl_hazard_detect #(
        .RS_W (RS_W)
    ) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_rmem    (ex_rmem),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            done_seen <= 1'b0;
            to_cnt    <= '0;
            mc_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_seen <= done_seen_nxt;
            to_cnt    <= to_cnt_nxt;
            if (mc_err_set) begin
                mc_err <= 1'b1;
            end
        end
    end

    always_comb begin
        ctl           = '0;
        state_nxt     = state;
        done_seen_nxt = done_seen;
        to_cnt_nxt    = to_cnt;
        mc_err_set    = 1'b0;

        // Timeout count keeps running through memory stalls; it saturates so a
        // long mem_wait cannot wrap it past the terminal value.
        if (state == MC_WAIT && to_cnt != TO_LAST) begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end

        if (mem_wait) begin
            ctl.stall_pc     = 1'b1;
            ctl.stall_if_id  = 1'b1;
            ctl.stall_id_ex  = 1'b1;
            ctl.stall_ex_mem = 1'b1;
            ctl.stall_mem_wb = 1'b1;
            if (state == MC_WAIT && ex_mc_done) begin
                done_seen_nxt = 1'b1;
            end
        end else if (state == MC_WAIT) begin
            if (ex_mc_done || done_seen) begin
                state_nxt     = RUN;
                done_seen_nxt = 1'b0;
            end else begin
                ctl.stall_pc     = 1'b1;
                ctl.stall_if_id  = 1'b1;
                ctl.stall_id_ex  = 1'b1;
                ctl.flush_ex_mem = 1'b1;
                if (to_cnt == TO_LAST) begin
                    mc_err_set = 1'b1;
                    state_nxt  = RUN;
                end
            end
        end else if (ex_branch_taken) begin
            ctl.flush_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
        end else if (ex_mc_start) begin
            ctl.stall_pc     = 1'b1;
            ctl.stall_if_id  = 1'b1;
            ctl.stall_id_ex  = 1'b1;
            ctl.flush_ex_mem = 1'b1;
            state_nxt        = MC_WAIT;
            to_cnt_nxt       = '0;
        end else if (load_use) begin
            ctl.stall_pc    = 1'b1;
            ctl.stall_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (ctl.stall_pc && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign stall_pc     = ctl.stall_pc;
    assign stall_if_id  = ctl.stall_if_id;
    assign stall_id_ex  = ctl.stall_id_ex;
    assign stall_ex_mem = ctl.stall_ex_mem;
    assign stall_mem_wb = ctl.stall_mem_wb;
    assign flush_if_id  = ctl.flush_if_id;
    assign flush_id_ex  = ctl.flush_id_ex;
    assign flush_ex_mem = ctl.flush_ex_mem;
    assign mc_busy      = (state == MC_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected control vectors.
module tb_pipe_hazard_ctrl;

    localparam int RS_W  = 6;
    localparam int CNT_W = 8;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
    //  flush_if_id, flush_id_ex, flush_ex_mem}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0010;
    localparam logic [7:0] C_BR   = 8'b0000_0110;
    localparam logic [7:0] C_MC   = 8'b1110_0001;
    localparam logic [7:0] C_MW   = 8'b1111_1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [RS_W-1:0]  id_rs1, id_rs2, ex_wd;
    logic             id_use_rs1, id_use_rs2, ex_wreg, ex_rmem;
    logic             ex_branch_taken, ex_mc_start, ex_mc_done, mem_wait;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic             flush_if_id, flush_id_ex, flush_ex_mem;
    logic             mc_busy, mc_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0]       ctl;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .RS_W       (RS_W),
        .MC_TIMEOUT (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_wd           (ex_wd),
        .ex_wreg         (ex_wreg),
        .ex_rmem         (ex_rmem),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .ex_mc_done      (ex_mc_done),
        .mem_wait        (mem_wait),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .mc_busy         (mc_busy),
        .mc_err          (mc_err),
        .stall_cycles    (stall_cycles)
    );

    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1          = '0;
        id_rs2          = '0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_wd           = '0;
        ex_wreg         = 1'b0;
        ex_rmem         = 1'b0;
        ex_branch_taken = 1'b0;
        ex_mc_start     = 1'b0;
        ex_mc_done      = 1'b0;
        mem_wait        = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic set_lu(input logic [RS_W-1:0] rd);
        ex_rmem    = 1'b1;
        ex_wreg    = 1'b1;
        ex_wd      = rd;
        id_use_rs2 = 1'b1;
        id_rs2     = rd;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl",  ctl,          C_NONE);
        chk("rst_busy", mc_busy,      0);
        chk("rst_err",  mc_err,       0);
        chk("rst_sc",   stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use variants
        nxt(); set_lu(6'd5); #1;
        chk("lu_rs2", ctl, C_LU);
        nxt(); #1;
        chk("lu_one_cycle", ctl, C_NONE);
        chk("lu_sc", stall_cycles, 1);
        nxt(); set_lu(6'd0); #1;
        chk("lu_x0", ctl, C_NONE);
        nxt(); ex_rmem = 1; ex_wreg = 1; ex_wd = 9; id_use_rs1 = 1; id_rs1 = 9; #1;
        chk("lu_rs1", ctl, C_LU);
        nxt(); ex_rmem = 1; ex_wreg = 1; ex_wd = 9; id_use_rs1 = 0; id_rs1 = 9; #1;
        chk("lu_nouse", ctl, C_NONE);
        nxt(); ex_rmem = 0; ex_wreg = 1; ex_wd = 9; id_use_rs1 = 1; id_rs1 = 9; #1;
        chk("lu_noload", ctl, C_NONE);
        nxt(); #1;
        chk("lu_sc2", stall_cycles, 2);

        // branch beats load-use and mc_start
        nxt(); set_lu(6'd5); ex_branch_taken = 1; #1;
        chk("br_lu", ctl, C_BR);
        nxt(); ex_branch_taken = 1; ex_mc_start = 1; #1;
        chk("br_mc", ctl, C_BR);
        nxt(); #1;
        chk("br_busy", mc_busy, 0);
        chk("br_sc", stall_cycles, 2);
        nxt(); ex_mc_done = 1; #1;
        chk("done_in_run", ctl, C_NONE);
        nxt(); #1;
        chk("done_in_run_busy", mc_busy, 0);

        // multi-cycle op, done 8 cycles after start
        nxt(); ex_mc_start = 1; #1;
        chk("mc_start", ctl, C_MC);
        chk("mc_start_busy", mc_busy, 0);
        for (int i = 1; i <= 7; i++) begin
            nxt();
            if (i == 3) begin
                set_lu(6'd5);
                ex_branch_taken = 1;
            end
            #1;
            chk($sformatf("mc_wait%0d", i), ctl, C_MC);
            chk($sformatf("mc_busy%0d", i), mc_busy, 1);
        end
        nxt(); ex_mc_done = 1; #1;
        chk("mc_done", ctl, C_NONE);
        chk("mc_done_busy", mc_busy, 1);
        nxt(); #1;
        chk("mc_after_busy", mc_busy, 0);
        chk("mc_sc", stall_cycles, 10);

        // mem_wait window inside MC_WAIT, done arrives during it
        nxt(); ex_mc_start = 1; #1;
        chk("mw_start", ctl, C_MC);
        nxt(); #1;
        chk("mw_pre1", ctl, C_MC);
        nxt(); #1;
        chk("mw_pre2", ctl, C_MC);
        for (int i = 0; i < 3; i++) begin
            nxt(); mem_wait = 1;
            if (i == 1) ex_mc_done = 1;
            #1;
            chk($sformatf("mw_stall%0d", i), ctl, C_MW);
            chk($sformatf("mw_busy%0d", i), mc_busy, 1);
        end
        nxt(); #1;
        chk("mw_release", ctl, C_NONE);
        chk("mw_release_busy", mc_busy, 1);
        nxt(); #1;
        chk("mw_run", mc_busy, 0);
        chk("mw_sc", stall_cycles, 16);
        nxt(); mem_wait = 1; ex_branch_taken = 1; #1;
        chk("mw_br", ctl, C_MW);
        nxt(); #1;
        chk("mw_br_sc", stall_cycles, 17);

        // timeout with MC_TIMEOUT=8
        nxt(); ex_mc_start = 1; #1;
        chk("to_start", ctl, C_MC);
        for (int i = 1; i <= 8; i++) begin
            nxt(); #1;
            chk($sformatf("to_wait%0d", i), ctl, C_MC);
            chk($sformatf("to_err%0d", i), mc_err, 0);
        end
        nxt(); #1;
        chk("to_release", ctl, C_NONE);
        chk("to_busy", mc_busy, 0);
        chk("to_err", mc_err, 1);
        nxt(); nxt(); nxt(); #1;
        chk("to_err_sticky", mc_err, 1);
        chk("to_sc", stall_cycles, 26);

        // async reset mid-MC_WAIT
        nxt(); ex_mc_start = 1;
        nxt(); nxt(); #1;
        chk("ar_pre_busy", mc_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", mc_busy, 0);
        chk("ar_sc", stall_cycles, 0);
        chk("ar_err", mc_err, 0);
        chk("ar_ctl", ctl, C_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        // stall counter saturation at 2^CNT_W-1
        nxt(); mem_wait = 1;
        repeat (254) @(negedge clk);
        #1;
        chk("sat_254", stall_cycles, 254);
        @(negedge clk); #1;
        chk("sat_255", stall_cycles, 255);
        repeat (4) @(negedge clk);
        #1;
        chk("sat_hold", stall_cycles, 255);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
